mem_bus_arbiter: RTL and testbench

Two-client arbiter that shares the single tagged memory bus between the instruction fetch port (client 1) and the data port (client 0). It sits between the two cache controllers and the memory model. It muxes one command per cycle onto the bus and records which client owns each issued load tag. It routes each returned load back to its owner and throttles clients that exceed an outstanding-load budget.

---
 rtl/mem_bus_arbiter_if.sv | 60 ++++++
 rtl/mem_bus_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: client, memory and status bundle of the memory bus
// arbiter. master = arbiter side, slave = clients + memory side.
//
// Client N (N = 0 data, 1 fetch):
//   cN_command/addr/wdata         client -> arbiter request
//   cN_response                   accepting tag this cycle, else 0
//   cN_rdata/cN_tag               load return, qualified by cN_tag != 0
//   cN_outstanding                loads accepted but not yet returned
// Memory:
//   proc2mem_command/addr/data    arbiter -> memory
//   mem2proc_response/data/tag    memory -> arbiter
// Status:
//   orphan_err                    sticky, a return hit an unowned tag
interface mem_bus_arbiter_if;
  logic [1:0]  c0_command;
  logic [31:0] c0_addr;
  logic [31:0] c0_wdata;
  logic [3:0]  c0_response;
  logic [31:0] c0_rdata;
  logic [3:0]  c0_tag;
  logic [3:0]  c0_outstanding;

  logic [1:0]  c1_command;
  logic [31:0] c1_addr;
  logic [31:0] c1_wdata;
  logic [3:0]  c1_response;
  logic [31:0] c1_rdata;
  logic [3:0]  c1_tag;
  logic [3:0]  c1_outstanding;

  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [31:0] proc2mem_data;

  logic [3:0]  mem2proc_response;
  logic [31:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;

  logic        orphan_err;

  modport master (
    input  c0_command, c0_addr, c0_wdata,
    input  c1_command, c1_addr, c1_wdata,
    input  mem2proc_response, mem2proc_data, mem2proc_tag,
    output c0_response, c0_rdata, c0_tag, c0_outstanding,
    output c1_response, c1_rdata, c1_tag, c1_outstanding,
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    output orphan_err
  );

  modport slave (
    output c0_command, c0_addr, c0_wdata,
    output c1_command, c1_addr, c1_wdata,
    output mem2proc_response, mem2proc_data, mem2proc_tag,
    input  c0_response, c0_rdata, c0_tag, c0_outstanding,
    input  c1_response, c1_rdata, c1_tag, c1_outstanding,
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    input  orphan_err
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-client round-robin arbiter for the tagged memory
// bus, with per-tag owner table and per-client outstanding-load budget.
//
// Ports:
//   clk     system clock, all state on posedge
//   rst_n   asynchronous active-low reset
//   io_bus  mem_bus_arbiter_if.master (client, memory, status signals)
module mem_bus_arbiter #(
  parameter int NUM_TAGS        = 15,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_bus_arbiter_if.master  io_bus
);

  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;
  localparam logic [3:0] MAX_OUT  = 4'(MAX_OUTSTANDING);

  // Per-tag state, bit t describes tag t (tag 0 means "none").
  logic [NUM_TAGS:1] r_valid;
  logic [NUM_TAGS:1] r_owner;

  logic        r_last_grant;
  logic [3:0]  r_out0;
  logic [3:0]  r_out1;
  logic        r_orphan;

  logic        w_elig0;
  logic        w_elig1;
  logic        w_any;
  logic        w_grant;
  logic [1:0]  w_gnt_cmd;
  logic [31:0] w_gnt_addr;
  logic [31:0] w_gnt_data;
  logic        w_accept;
  logic        w_alloc;
  logic        w_ret_hit;
  logic        w_ret_owner;
  logic        w_orphan;
  logic        w_inc0;
  logic        w_inc1;
  logic        w_dec0;
  logic        w_dec1;

  // A load at budget is masked; anything else non-NONE is a store
  // and is always eligible.
  assign w_elig0 = (io_bus.c0_command != BUS_NONE) &&
                   !((io_bus.c0_command == BUS_LOAD) &&
                     (r_out0 == MAX_OUT));
  assign w_elig1 = (io_bus.c1_command != BUS_NONE) &&
                   !((io_bus.c1_command == BUS_LOAD) &&
                     (r_out1 == MAX_OUT));
  assign w_any   = w_elig0 | w_elig1;

  always_comb begin
    w_grant = 1'b0;
    unique case (1'b1)
      (w_elig0 && w_elig1):  w_grant = ~r_last_grant;
      (w_elig1 && !w_elig0): w_grant = 1'b1;
      default:               w_grant = 1'b0;
    endcase
  end

  always_comb begin
    w_gnt_cmd  = BUS_NONE;
    w_gnt_addr = '0;
    w_gnt_data = '0;
    if (w_any) begin
      if (w_grant) begin
        w_gnt_cmd  = io_bus.c1_command;
        w_gnt_addr = io_bus.c1_addr;
        w_gnt_data = io_bus.c1_wdata;
      end else begin
        w_gnt_cmd  = io_bus.c0_command;
        w_gnt_addr = io_bus.c0_addr;
        w_gnt_data = io_bus.c0_wdata;
      end
    end
  end

  assign io_bus.proc2mem_command = w_gnt_cmd;
  assign io_bus.proc2mem_addr    = w_gnt_addr;
  assign io_bus.proc2mem_data    = w_gnt_data;

  assign io_bus.c0_response =
    (w_any && !w_grant) ? io_bus.mem2proc_response : 4'd0;
  assign io_bus.c1_response =
    (w_any && w_grant) ? io_bus.mem2proc_response : 4'd0;

  assign w_accept = w_any && (io_bus.mem2proc_response != 4'd0);
  assign w_alloc  = w_accept && (w_gnt_cmd == BUS_LOAD);

  // Owner lookup for the returning tag.
  always_comb begin
    w_ret_hit   = 1'b0;
    w_ret_owner = 1'b0;
    for (int t = 1; t <= NUM_TAGS; t++) begin
      if ((io_bus.mem2proc_tag == 4'(t)) && r_valid[t]) begin
        w_ret_hit   = 1'b1;
        w_ret_owner = r_owner[t];
      end
    end
  end

  assign w_orphan = (io_bus.mem2proc_tag != 4'd0) && !w_ret_hit;

  assign io_bus.c0_tag =
    (w_ret_hit && !w_ret_owner) ? io_bus.mem2proc_tag : 4'd0;
  assign io_bus.c1_tag =
    (w_ret_hit && w_ret_owner) ? io_bus.mem2proc_tag : 4'd0;
  assign io_bus.c0_rdata = io_bus.mem2proc_data;
  assign io_bus.c1_rdata = io_bus.mem2proc_data;

  assign w_inc0 = w_alloc && !w_grant;
  assign w_inc1 = w_alloc && w_grant;
  assign w_dec0 = w_ret_hit && !w_ret_owner;
  assign w_dec1 = w_ret_hit && w_ret_owner;

  assign io_bus.c0_outstanding = r_out0;
  assign io_bus.c1_outstanding = r_out1;
  assign io_bus.orphan_err     = r_orphan;

  function automatic logic [3:0] f_next_cnt(
    input logic [3:0] cnt,
    input logic       inc,
    input logic       dec
  );
    logic [3:0] nxt;
    nxt = cnt;
    unique case ({inc, dec})
      2'b10:   nxt = cnt + 4'd1;
      2'b01:   nxt = cnt - 4'd1;
      default: nxt = cnt;
    endcase
    return nxt;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_out0       <= '0;
      r_out1       <= '0;
      r_orphan     <= 1'b0;
    end else begin
      if (w_accept) r_last_grant <= w_grant;
      r_out0   <= f_next_cnt(r_out0, w_inc0, w_dec0);
      r_out1   <= f_next_cnt(r_out1, w_inc1, w_dec1);
      r_orphan <= r_orphan | w_orphan;
    end
  end

  // Free on return, then allocate; memory never reuses a tag on the
  // cycle it returns it, so the two never hit the same entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_owner <= '0;
    end else begin
      for (int t = 1; t <= NUM_TAGS; t++) begin
        if (w_ret_hit && (io_bus.mem2proc_tag == 4'(t)))
          r_valid[t] <= 1'b0;
        if (w_alloc && (io_bus.mem2proc_response == 4'(t))) begin
          r_valid[t] <= 1'b1;
          r_owner[t] <= w_grant;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed bench for mem_bus_arbiter, with a
// default instance and a MAX_OUTSTANDING=2 instance for throttling.
module tb_mem_bus_arbiter;

  localparam logic [1:0] NONE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] STORE = 2'd2;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  mem_bus_arbiter_if bi();
  mem_bus_arbiter_if bt();

  mem_bus_arbiter u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bi.master)
  );

  mem_bus_arbiter #(.MAX_OUTSTANDING(2)) u_thr (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bt.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h exp %h", tag, got, exp);
  endtask

  task automatic idle();
    bi.c0_command = NONE; bi.c0_addr = '0; bi.c0_wdata = '0;
    bi.c1_command = NONE; bi.c1_addr = '0; bi.c1_wdata = '0;
    bi.mem2proc_response = '0;
    bi.mem2proc_data = '0;
    bi.mem2proc_tag = '0;
    bt.c0_command = NONE; bt.c0_addr = '0; bt.c0_wdata = '0;
    bt.c1_command = NONE; bt.c1_addr = '0; bt.c1_wdata = '0;
    bt.mem2proc_response = '0;
    bt.mem2proc_data = '0;
    bt.mem2proc_tag = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int          rt[6] = '{1, 2, 3, 4, 5, 6};
  bit          ro[6] = '{0, 1, 0, 1, 1, 0};
  int          e0[6] = '{1, 1, 1, 1, 1, 0};
  int          e1[6] = '{3, 2, 2, 1, 0, 0};
  logic [31:0] d;

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    #1;
    check("rst_out0", 32'(bi.c0_outstanding), 0);
    check("rst_out1", 32'(bi.c1_outstanding), 0);
    check("rst_cmd", 32'(bi.proc2mem_command), 32'(NONE));
    check("rst_resp0", 32'(bi.c0_response), 0);
    check("rst_orphan", 32'(bi.orphan_err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // single load
    @(negedge clk);
    bi.c0_command = LOAD; bi.c0_addr = 32'h100;
    bi.mem2proc_response = 4'd1;
    #1;
    check("sl_cmd", 32'(bi.proc2mem_command), 32'(LOAD));
    check("sl_addr", bi.proc2mem_addr, 32'h100);
    check("sl_resp0", 32'(bi.c0_response), 1);
    check("sl_resp1", 32'(bi.c1_response), 0);
    @(posedge clk); #1;
    check("sl_out0", 32'(bi.c0_outstanding), 1);
    @(negedge clk);
    idle();
    bi.mem2proc_tag = 4'd1; bi.mem2proc_data = 32'hCAFE0001;
    #1;
    check("sl_tag0", 32'(bi.c0_tag), 1);
    check("sl_tag1", 32'(bi.c1_tag), 0);
    check("sl_rdata0", bi.c0_rdata, 32'hCAFE0001);
    check("sl_rdata1", bi.c1_rdata, 32'hCAFE0001);
    @(posedge clk); #1;
    check("sl_out0_ret", 32'(bi.c0_outstanding), 0);
    check("sl_orphan", 32'(bi.orphan_err), 0);

    // contention from reset: c0, c1, c0, c1
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      idle();
      bi.c0_command = LOAD; bi.c0_addr = 32'h1000;
      bi.c1_command = LOAD; bi.c1_addr = 32'h2000;
      bi.mem2proc_response = 4'(k + 1);
      #1;
      check("ct_resp0", 32'(bi.c0_response),
            (k % 2 == 0) ? 32'(k + 1) : 0);
      check("ct_resp1", 32'(bi.c1_response),
            (k % 2 == 1) ? 32'(k + 1) : 0);
      check("ct_addr", bi.proc2mem_addr,
            (k % 2 == 0) ? 32'h1000 : 32'h2000);
    end
    @(posedge clk); #1;
    check("ct_out0", 32'(bi.c0_outstanding), 2);
    check("ct_out1", 32'(bi.c1_outstanding), 2);

    // returns, with same-cycle allocate on R1 (other) and R3 (same)
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      idle();
      d = 32'hA0000000 + 32'(i);
      bi.mem2proc_tag = 4'(rt[i]);
      bi.mem2proc_data = d;
      if (i == 0) begin
        bi.c1_command = LOAD; bi.c1_addr = 32'h2100;
        bi.mem2proc_response = 4'd5;
      end
      if (i == 2) begin
        bi.c0_command = LOAD; bi.c0_addr = 32'h1100;
        bi.mem2proc_response = 4'd6;
      end
      #1;
      check("rt_tag0", 32'(bi.c0_tag), ro[i] ? 0 : 32'(rt[i]));
      check("rt_tag1", 32'(bi.c1_tag), ro[i] ? 32'(rt[i]) : 0);
      if (i == 0) check("rt_alloc1", 32'(bi.c1_response), 5);
      if (i == 2) check("rt_alloc0", 32'(bi.c0_response), 6);
      @(posedge clk); #1;
      check("rt_out0", 32'(bi.c0_outstanding), 32'(e0[i]));
      check("rt_out1", 32'(bi.c1_outstanding), 32'(e1[i]));
    end

    // store from c1
    @(negedge clk);
    idle();
    bi.c1_command = STORE; bi.c1_addr = 32'h200;
    bi.c1_wdata = 32'hDEADBEEF;
    bi.mem2proc_response = 4'd7;
    #1;
    check("st_cmd", 32'(bi.proc2mem_command), 32'(STORE));
    check("st_addr", bi.proc2mem_addr, 32'h200);
    check("st_data", bi.proc2mem_data, 32'hDEADBEEF);
    check("st_resp1", 32'(bi.c1_response), 7);
    check("st_resp0", 32'(bi.c0_response), 0);
    @(posedge clk); #1;
    check("st_out1", 32'(bi.c1_outstanding), 0);
    check("st_out0", 32'(bi.c0_outstanding), 0);

    // rejection hold: last grant was c1, so c0 holds the grant
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      idle();
      bi.c0_command = LOAD; bi.c0_addr = 32'h3000;
      bi.c1_command = LOAD; bi.c1_addr = 32'h4000;
      bi.mem2proc_response = (k == 2) ? 4'd8 : 4'd0;
      #1;
      check("rj_addr", bi.proc2mem_addr, 32'h3000);
      check("rj_resp0", 32'(bi.c0_response), (k == 2) ? 8 : 0);
      check("rj_resp1", 32'(bi.c1_response), 0);
    end
    @(negedge clk);
    idle();
    bi.c0_command = LOAD; bi.c0_addr = 32'h3004;
    bi.c1_command = LOAD; bi.c1_addr = 32'h4000;
    bi.mem2proc_response = 4'd9;
    #1;
    check("rj_mv_addr", bi.proc2mem_addr, 32'h4000);
    check("rj_mv_resp1", 32'(bi.c1_response), 9);
    check("rj_mv_resp0", 32'(bi.c0_response), 0);
    @(negedge clk);
    idle();
    bi.c0_command = LOAD; bi.c0_addr = 32'h3004;
    bi.mem2proc_response = 4'd10;
    #1;
    check("rj_c0_resp", 32'(bi.c0_response), 10);
    @(posedge clk); #1;
    check("rj_out0", 32'(bi.c0_outstanding), 2);
    check("rj_out1", 32'(bi.c1_outstanding), 1);

    // reset mid-flight, then a stale return
    idle();
    rst_n = 1'b0;
    #1;
    check("mr_out0", 32'(bi.c0_outstanding), 0);
    check("mr_out1", 32'(bi.c1_outstanding), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bi.mem2proc_tag = 4'd8; bi.mem2proc_data = 32'h5555AAAA;
    #1;
    check("or_tag0", 32'(bi.c0_tag), 0);
    check("or_tag1", 32'(bi.c1_tag), 0);
    check("or_pre", 32'(bi.orphan_err), 0);
    @(posedge clk); #1;
    check("or_set", 32'(bi.orphan_err), 1);
    @(negedge clk);
    idle();
    @(posedge clk); #1;
    check("or_sticky", 32'(bi.orphan_err), 1);

    // throttle on the MAX_OUTSTANDING=2 instance
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      idle();
      bt.c0_command = LOAD; bt.c0_addr = 32'h500 + 32'(4 * k);
      bt.mem2proc_response = 4'(k + 1);
      #1;
      check("th_resp", 32'(bt.c0_response), 32'(k + 1));
      @(posedge clk); #1;
      check("th_out", 32'(bt.c0_outstanding), 32'(k + 1));
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      idle();
      bt.c0_command = LOAD; bt.c0_addr = 32'h508;
      bt.mem2proc_response = 4'd3;
      if (k == 1) bt.mem2proc_tag = 4'd1;
      #1;
      check("th_mask_resp", 32'(bt.c0_response), 0);
      check("th_mask_cmd", 32'(bt.proc2mem_command), 32'(NONE));
      if (k == 1) check("th_ret_tag", 32'(bt.c0_tag), 1);
      @(posedge clk); #1;
      check("th_mask_out", 32'(bt.c0_outstanding), (k == 1) ? 1 : 2);
    end
    @(negedge clk);
    idle();
    bt.c0_command = LOAD; bt.c0_addr = 32'h508;
    bt.mem2proc_response = 4'd3;
    #1;
    check("th_acc_resp", 32'(bt.c0_response), 3);
    check("th_acc_addr", bt.proc2mem_addr, 32'h508);
    @(posedge clk); #1;
    check("th_acc_out", 32'(bt.c0_outstanding), 2);
    for (int k = 2; k <= 3; k++) begin
      @(negedge clk);
      idle();
      bt.mem2proc_tag = 4'(k);
      #1;
      check("th_drain_tag", 32'(bt.c0_tag), 32'(k));
    end
    @(posedge clk); #1;
    check("th_drain_out", 32'(bt.c0_outstanding), 0);

    // directed unallocated tag 5
    @(negedge clk);
    idle();
    bt.mem2proc_tag = 4'd5;
    #1;
    check("u5_tag0", 32'(bt.c0_tag), 0);
    check("u5_tag1", 32'(bt.c1_tag), 0);
    check("u5_pre", 32'(bt.orphan_err), 0);
    @(posedge clk); #1;
    check("u5_set", 32'(bt.orphan_err), 1);
    @(negedge clk);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
